// File: rtl/if_stage.sv
// Instruction-fetch stage: 64-word instruction memory, fetch PC and the IF/ID
// pipeline register. Branches resolved in ID redirect the PC and flush IF/ID.
module if_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        br_taken,
   input  logic [31:0] br_offset,
   input  logic        imem_we,
   input  logic [5:0]  imem_waddr,
   input  logic [31:0] imem_wdata,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic [31:0] pc,
   output logic [15:0] fetch_count
);

   logic [31:0] r_imem [64];
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc_out;
   logic [15:0] r_cnt;

   logic [31:0] w_fetch;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_target;

   // Not reset: program contents must survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (imem_we)
         r_imem[imem_waddr] <= imem_wdata;
   end

   always_comb begin
      w_fetch    = r_imem[r_pc[7:2]];
      w_pc_plus4 = r_pc + 32'd4;
      w_target   = r_pc_out + (br_offset << 2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= '0;
         r_instr  <= '0;
         r_pc_out <= '0;
         r_cnt    <= '0;
      end else if (br_taken) begin
         r_pc     <= w_target;
         r_instr  <= '0;
         r_pc_out <= '0;
      end else if (!freeze) begin
         r_pc     <= w_pc_plus4;
         r_instr  <= w_fetch;
         r_pc_out <= w_pc_plus4;
         if (r_cnt != '1)
            r_cnt <= r_cnt + 16'd1;
      end
   end

   always_comb begin
      pc          = r_pc;
      instruction = r_instr;
      pc_out      = r_pc_out;
      fetch_count = r_cnt;
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: stimulus tables and hand sequences push
// expected IF/ID state into a scoreboard queue that is checked after each edge.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        freeze = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_offset = '0;
   logic        imem_we = 1'b0;
   logic [5:0]  imem_waddr = '0;
   logic [31:0] imem_wdata = '0;
   logic [31:0] instruction, pc_out, pc;
   logic [15:0] fetch_count;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic        frz;
      logic        br;
      logic [31:0] off;
      logic [31:0] e_instr;
      logic [31:0] e_pc_out;
      logic [31:0] e_pc;
      logic [15:0] e_cnt;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] e_instr;
      logic [31:0] e_pc_out;
      logic [31:0] e_pc;
      logic [15:0] e_cnt;
   } exp_t;

   exp_t sb[$];

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .freeze      (freeze),
      .br_taken    (br_taken),
      .br_offset   (br_offset),
      .imem_we     (imem_we),
      .imem_waddr  (imem_waddr),
      .imem_wdata  (imem_wdata),
      .instruction (instruction),
      .pc_out      (pc_out),
      .pc          (pc),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input exp_t e);
      check({e.name, ".instr"},  instruction, e.e_instr);
      check({e.name, ".pc_out"}, pc_out,      e.e_pc_out);
      check({e.name, ".pc"},     pc,          e.e_pc);
      check({e.name, ".count"},  {16'h0, fetch_count}, {16'h0, e.e_cnt});
   endtask

   // Drive one cycle of inputs, queue the expected post-edge state, then check it.
   task automatic step(input string name, input logic frz, input logic br, input logic [31:0] off,
                       input logic [31:0] ei, input logic [31:0] epo, input logic [31:0] epc,
                       input logic [15:0] ecnt);
      exp_t e;
      freeze    = frz;
      br_taken  = br;
      br_offset = off;
      e.name = name; e.e_instr = ei; e.e_pc_out = epo; e.e_pc = epc; e.e_cnt = ecnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: scoreboard empty, got %h expected an entry", name, instruction);
      end else begin
         check_all(sb.pop_front());
      end
      freeze = 1'b0; br_taken = 1'b0; br_offset = '0;
   endtask

   task automatic do_reset(input string name);
      exp_t z;
      rst = 1'b1;
      #2;
      z.name = name; z.e_instr = '0; z.e_pc_out = '0; z.e_pc = '0; z.e_cnt = '0;
      check_all(z);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic mem_write(input logic [5:0] a, input logic [31:0] d);
      imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
      @(posedge clk);
      #1;
      imem_we = 1'b0;
   endtask

   vec_t run30[4];
   vec_t run31[6];

   initial begin
      run30[0] = '{1'b0, 1'b0, 32'h0, 32'h11, 32'd4,  32'd4,  16'd1};
      run30[1] = '{1'b0, 1'b0, 32'h0, 32'h22, 32'd8,  32'd8,  16'd2};
      run30[2] = '{1'b0, 1'b0, 32'h0, 32'h33, 32'd12, 32'd12, 16'd3};
      run30[3] = '{1'b0, 1'b0, 32'h0, 32'h44, 32'd16, 32'd16, 16'd4};

      run31[0] = '{1'b0, 1'b0, 32'h0, 32'h11, 32'd4,  32'd4,  16'd1};
      run31[1] = '{1'b0, 1'b0, 32'h0, 32'h22, 32'd8,  32'd8,  16'd2};
      run31[2] = '{1'b1, 1'b0, 32'h0, 32'h22, 32'd8,  32'd8,  16'd2};
      run31[3] = '{1'b1, 1'b0, 32'h0, 32'h22, 32'd8,  32'd8,  16'd2};
      run31[4] = '{1'b0, 1'b0, 32'h0, 32'h33, 32'd12, 32'd12, 16'd3};
      run31[5] = '{1'b0, 1'b0, 32'h0, 32'h44, 32'd16, 32'd16, 16'd4};

      // Program load while held in reset: words 0..3 as given, others 0x1000+index.
      #1;
      for (int unsigned i = 0; i < 64; i++) begin
         case (i)
            0: mem_write(6'(i), 32'h11);
            1: mem_write(6'(i), 32'h22);
            2: mem_write(6'(i), 32'h33);
            3: mem_write(6'(i), 32'h44);
            default: mem_write(6'(i), 32'h1000 + i);
         endcase
      end

      do_reset("rst0");
      for (int unsigned i = 0; i < 4; i++)
         step($sformatf("run30[%0d]", i), run30[i].frz, run30[i].br, run30[i].off,
              run30[i].e_instr, run30[i].e_pc_out, run30[i].e_pc, run30[i].e_cnt);

      do_reset("rst1");
      for (int unsigned i = 0; i < 6; i++)
         step($sformatf("run31[%0d]", i), run31[i].frz, run31[i].br, run31[i].off,
              run31[i].e_instr, run31[i].e_pc_out, run31[i].e_pc, run31[i].e_cnt);

      // Branch from pc_out=8, offset 3 -> 20, then fetch word 5
      do_reset("rst2");
      step("b32.a", 0, 0, 0, 32'h11, 32'd4, 32'd4, 16'd1);
      step("b32.b", 0, 0, 0, 32'h22, 32'd8, 32'd8, 16'd2);
      step("b32.br", 0, 1, 32'd3, 32'h0, 32'd0, 32'd20, 16'd2);
      step("b32.nx", 0, 0, 0, 32'h1005, 32'd24, 32'd24, 16'd3);

      // Branch wins over freeze; negative offset
      do_reset("rst3");
      for (int unsigned i = 0; i < 4; i++)
         step("b33.pre", 0, 0, 0, run30[i].e_instr, run30[i].e_pc_out, run30[i].e_pc, run30[i].e_cnt);
      step("b33.br", 1, 1, 32'hFFFF_FFFE, 32'h0, 32'd0, 32'd8, 16'd4);
      step("b33.nx", 0, 0, 0, 32'h33, 32'd12, 32'd12, 16'd5);

      // Wrap below zero: pc_out=4, offset -8 -> FFFFFFE4, word 57
      do_reset("rst4");
      step("w33.a", 0, 0, 0, 32'h11, 32'd4, 32'd4, 16'd1);
      step("w33.br", 0, 1, 32'hFFFF_FFF8, 32'h0, 32'd0, 32'hFFFF_FFE4, 16'd1);
      step("w33.nx", 0, 0, 0, 32'h1039, 32'hFFFF_FFE8, 32'hFFFF_FFE8, 16'd2);

      // pc=252 advances to 256 and wraps the fetch to word 0
      do_reset("rst5");
      step("p34.a", 0, 0, 0, 32'h11, 32'd4, 32'd4, 16'd1);
      step("p34.br", 0, 1, 32'd62, 32'h0, 32'd0, 32'd252, 16'd1);
      step("p34.w63", 0, 0, 0, 32'h103F, 32'd256, 32'd256, 16'd2);
      step("p34.w0", 0, 0, 0, 32'h11, 32'd260, 32'd260, 16'd3);

      // Same-cycle write to the word being fetched returns the old word
      do_reset("rst6");
      step("m34.a", 0, 0, 0, 32'h11, 32'd4, 32'd4, 16'd1);
      step("m34.br", 0, 1, 32'd4, 32'h0, 32'd0, 32'd20, 16'd1);
      imem_we = 1'b1; imem_waddr = 6'd5; imem_wdata = 32'hDEAD_BEEF;
      step("m34.old", 0, 0, 0, 32'h1005, 32'd24, 32'd24, 16'd2);
      imem_we = 1'b0;
      step("m34.back", 0, 1, 32'hFFFF_FFFF, 32'h0, 32'd0, 32'd20, 16'd2);
      step("m34.new", 0, 0, 0, 32'hDEAD_BEEF, 32'd24, 32'd24, 16'd3);

      // Asynchronous reset between edges during a freeze
      step("r35.a", 0, 0, 0, 32'h1006, 32'd28, 32'd28, 16'd4);
      freeze = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("r35.instr",  instruction, 32'h0);
      check("r35.pc_out", pc_out,      32'h0);
      check("r35.pc",     pc,          32'h0);
      check("r35.count",  {16'h0, fetch_count}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      freeze = 1'b0;
      step("r35.first", 0, 0, 0, 32'h11, 32'd4, 32'd4, 16'd1);

      // Saturation of the fetch counter
      do_reset("rst7");
      repeat (65535) @(posedge clk);
      #1;
      check("sat.full", {16'h0, fetch_count}, 32'h0000_FFFF);
      check("sat.pc",   pc, 32'h0003_FFFC);
      @(posedge clk);
      #1;
      check("sat.hold", {16'h0, fetch_count}, 32'h0000_FFFF);
      check("sat.pc2",  pc, 32'h0004_0000);

      if (sb.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
